lifo_stack: RTL
===============

Name: lifo_stack

Overview:
- Parametrised true last-in/first-out stack with occupancy count, almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Single clock domain. Serves as a general-purpose buffer for return-address, undo and nesting structures in the memories library.
- Successor to the FIFO-style register-file buffer: it generalises depth to any value ≥ 2 (not only powers of two) and defines simultaneous push/pop as "replace top".

Parameters:
pBITS, 8, data word width in bits.
pDEPTH, 16, number of entries; any integer ≥ 2.
pALMOST_FULL, 14, oalmost_full asserted when count ≥ this value; legal range 1..pDEPTH.
pALMOST_EMPTY, 2, oalmost_empty asserted when count ≤ this value; legal range 0..pDEPTH-1.

Ports:
iclk  input  1  clock; all state updates on the rising edge.
ireset  input  1  reset, asynchronous, active-high; clears all state.
ipush  input  1  push request.
ipop  input  1  pop request.
iw_data  input  pBITS  data to push.
or_data  output  pBITS  top-of-stack word; 0 when empty.
ocount  output  $clog2(pDEPTH+1)  current occupancy, 0..pDEPTH.
oempty  output  1  count == 0.
ofull  output  1  count == pDEPTH.
oalmost_full  output  1  count ≥ pALMOST_FULL.
oalmost_empty  output  1  count ≤ pALMOST_EMPTY.
ooverflow  output  1  one-cycle pulse: push rejected.
ounderflow  output  1  one-cycle pulse: pop rejected.

Behaviour:
- Storage: pDEPTH x pBITS register array, not reset. A stack pointer equal to count indexes the next free slot; top is at index count-1.
- Reset (async assert, released synchronously by the user) sets the following, independent of any in-flight operation:
  - ocount=0, oempty=1, ofull=0, oalmost_full=0 (when pALMOST_FULL>0), oalmost_empty=1, ooverflow=0, ounderflow=0, or_data=0.
- or_data is a combinational read of array[count-1], muxed to 0 when empty. A push at edge N appears on or_data after edge N.
- Operations per rising edge, selected by {ipush, ipop}:
  - 00: hold.
  - 10, not full: array[count] <= iw_data; count+1.
  - 10, full: no write; count unchanged; ooverflow=1 for one cycle.
  - 01, not empty: count-1; new top is visible after the edge.
  - 01, empty: count stays 0; ounderflow=1 for one cycle.
  - 11, not empty (including full): array[count-1] <= iw_data (replace top); count unchanged; no error pulse.
  - 11, empty: treated as push (array[0] <= iw_data, count=1); ounderflow=1 for one cycle (pop portion rejected).
- All status flags and count are registered and computed from the next count value, so they are consistent with ocount in the same cycle. No combinational path from ipush/ipop to any output.
- ooverflow/ounderflow are high only in the cycle following the offending edge; they are low otherwise.
- Count arithmetic is width-safe for non-power-of-two pDEPTH; the pointer never exceeds pDEPTH and never wraps.

Optional Feature:
- Macro: LIFO_STACK_CLEAR_EN.
- Defined: adds input port iclear (1 bit), a synchronous flush with highest priority over push/pop.
  - On an edge with iclear=1: count=0, oempty=1, oalmost_empty=1, ofull=0, oalmost_full=0, or_data=0.
  - Any simultaneous push/pop is ignored; no error pulses.
- Undefined: iclear port absent; only ireset empties the stack.

Test Plan:
- Reset then idle: ocount=0, oempty=1, oalmost_empty=1, or_data=0, no error pulses for 10 cycles.
- pDEPTH=4: push 0x11,0x22,0x33,0x44 -> ofull=1, ocount=4, or_data=0x44; then pop x4 -> or_data reads 0x33, 0x22, 0x11, 0 in turn; oempty=1.
- Full stack (pDEPTH=4), push 0x55 -> ooverflow pulse for exactly 1 cycle, ocount=4, or_data stays 0x44.
- Empty stack, pop -> ounderflow 1 cycle, ocount=0. Empty, push+pop 0xAA -> ocount=1, or_data=0xAA, ounderflow 1 cycle.
- Count 2 (top 0x22), push+pop 0x99 -> ocount=2, or_data=0x99; pop -> or_data=0x11.
- pDEPTH=5, pALMOST_FULL=4, pALMOST_EMPTY=1: push 5 words, checking oalmost_empty falls when count reaches 2 and oalmost_full rises at count=4. Assert ireset mid-sequence -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised last-in/first-out stack with occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow error pulses.
//
// A simultaneous push and pop replaces the top word. A push and pop on an
// empty stack acts as a plain push and raises ounderflow for the rejected pop.
//
// Optional feature: define LIFO_STACK_CLEAR_EN to add the iclear input. It is a
// synchronous flush with priority over push/pop and raises no error pulses.
//
// Ports:
//   iclk           clock, rising edge
//   ireset         asynchronous active-high reset
//   iclear         synchronous flush (only with LIFO_STACK_CLEAR_EN)
//   ipush, ipop    operation request
//   iw_data        word to push
//   or_data        top-of-stack word, 0 when empty (combinational read)
//   ocount         occupancy 0..pDEPTH
//   oempty, ofull, oalmost_full, oalmost_empty   registered status flags
//   ooverflow      one-cycle pulse: push rejected (stack full)
//   ounderflow     one-cycle pulse: pop rejected (stack empty)
module lifo_stack #(
  parameter int unsigned pBITS         = 8,
  parameter int unsigned pDEPTH        = 16,
  parameter int unsigned pALMOST_FULL  = 14,
  parameter int unsigned pALMOST_EMPTY = 2
) (
  input  logic                         iclk,
  input  logic                         ireset,
`ifdef LIFO_STACK_CLEAR_EN
  input  logic                         iclear,
`endif
  input  logic                         ipush,
  input  logic                         ipop,
  input  logic [pBITS-1:0]             iw_data,
  output logic [pBITS-1:0]             or_data,
  output logic [$clog2(pDEPTH+1)-1:0]  ocount,
  output logic                         oempty,
  output logic                         ofull,
  output logic                         oalmost_full,
  output logic                         oalmost_empty,
  output logic                         ooverflow,
  output logic                         ounderflow
);

  localparam int unsigned lCntW  = $clog2(pDEPTH + 1);
  localparam int unsigned lAddrW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;

  logic [pBITS-1:0]  mem [pDEPTH];
  logic [lCntW-1:0]  count;
  logic [lCntW-1:0]  countNext;
  logic              wrEn;
  logic [lAddrW-1:0] wrAddr;
  logic [lAddrW-1:0] rdAddr;
  logic              overflowNext;
  logic              underflowNext;
  logic              isEmpty;
  logic              isFull;

  assign isEmpty = (count == '0);
  assign isFull  = (count == lCntW'(pDEPTH));

  // Next count, write strobe and error pulses for this edge.
  always_comb begin
    countNext     = count;
    wrEn          = 1'b0;
    wrAddr        = '0;
    overflowNext  = 1'b0;
    underflowNext = 1'b0;
    unique case ({ipush, ipop})
      2'b10: begin
        if (isFull) begin
          overflowNext = 1'b1;
        end else begin
          wrEn      = 1'b1;
          wrAddr    = lAddrW'(count);
          countNext = count + lCntW'(1);
        end
      end
      2'b01: begin
        if (isEmpty) begin
          underflowNext = 1'b1;
        end else begin
          countNext = count - lCntW'(1);
        end
      end
      2'b11: begin
        wrEn = 1'b1;
        if (isEmpty) begin
          // Pop half is rejected; the push half still lands in slot 0.
          wrAddr        = '0;
          countNext     = lCntW'(1);
          underflowNext = 1'b1;
        end else begin
          wrAddr = lAddrW'(count - lCntW'(1));
        end
      end
      default: ;
    endcase
`ifdef LIFO_STACK_CLEAR_EN
    if (iclear) begin
      countNext     = '0;
      wrEn          = 1'b0;
      overflowNext  = 1'b0;
      underflowNext = 1'b0;
    end
`endif
  end

  // Count and status flags, all derived from the next count.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      count         <= '0;
      oempty        <= 1'b1;
      ofull         <= 1'b0;
      oalmost_full  <= 1'b0;
      oalmost_empty <= 1'b1;
      ooverflow     <= 1'b0;
      ounderflow    <= 1'b0;
    end else begin
      count         <= countNext;
      oempty        <= (countNext == '0);
      ofull         <= (countNext == lCntW'(pDEPTH));
      oalmost_full  <= (countNext >= lCntW'(pALMOST_FULL));
      oalmost_empty <= (countNext <= lCntW'(pALMOST_EMPTY));
      ooverflow     <= overflowNext;
      ounderflow    <= underflowNext;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge iclk) begin
    if (wrEn) begin
      mem[wrAddr] <= iw_data;
    end
  end

  assign ocount  = count;
  assign rdAddr  = lAddrW'(count - lCntW'(1));
  assign or_data = isEmpty ? '0 : mem[rdAddr];

endmodule
